serial_char_rx_ctrl: RTL and testbench



---
 rtl/serial_char_pkg.sv | 19 +
 rtl/char_fifo_fwft.sv | 68 ++++++
 rtl/serial_char_rx_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_char_rx_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_char_pkg.sv
// Shared types and helpers for the framed 7-bit serial character receiver.
package serial_char_pkg;

    localparam int CHAR_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Even parity of a character: 1 when it holds an odd number of ones.
    function automatic logic parity_of(input logic [CHAR_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/char_fifo_fwft.sv
// First-word-fall-through FIFO: dout always shows the head entry; count is exact 0..DEPTH.
module char_fifo_fwft #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is still taken when the head leaves on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/serial_char_rx_ctrl.sv
// Framed serial character receiver: start detect, MSB-first data, optional parity, stop check, FWFT output.
//
// state  | meaning
// IDLE   | line idle, waiting for a strobe sampling a 0 start bit
// DATA   | shifting in DATA_W data bits, MSB first
// PARITY | sampling parity bit, latching any mismatch
// STOP   | sampling stop bit; push, parity error, or framing error
// BREAK  | line held low after a framing error; wait for a 1 before re-arming
module serial_char_rx_ctrl
    import serial_char_pkg::*;
#(
    parameter int DATA_W     = CHAR_W,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    localparam int CNT_W     = $clog2(DATA_W + 1),
    localparam int FCW       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              in,
    output logic [DATA_W-1:0] out,
    output logic              on,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overflow,
    output logic [FCW-1:0]    fifo_count
);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_bad_q, par_bad_d;
    logic              frame_err_q, frame_err_d;
    logic              parity_err_q, parity_err_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              fifo_pop, fifo_full, fifo_empty;

    assign on         = !fifo_empty;
    assign fifo_pop   = on && out_ready;
    assign busy       = (state_q != IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overflow   = overflow_q;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push         = 1'b0;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!in) begin
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    shift_d   = {shift_q[DATA_W-2:0], in};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_bad_d = ((parity_of(shift_q) ^ in) != (PARITY_ODD != 0));
                    state_d   = STOP;
                end
                STOP: begin
                    if (in) begin
                        if (par_bad_q) parity_err_d = 1'b1;
                        else           push         = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
                BREAK: begin
                    if (in) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        overflow_d = push && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

    char_fifo_fwft #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (shift_q),
        .pop   (fifo_pop),
        .dout  (out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_serial_char_rx_ctrl.sv
// Bench for serial_char_rx_ctrl: directed frames plus randomized traffic against a frame-level model.
module tb_serial_char_rx_ctrl;

    localparam int DATA_W = 7;
    localparam int DEPTH  = 4;
    localparam int PEN    = 1;
    localparam int PODD   = 0;
    localparam int FCW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              bit_en = 1'b0;
    logic              in_s = 1'b1;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out;
    logic              on, busy, frame_err, parity_err, overflow;
    logic [FCW-1:0]    fifo_count;

    always #5 clk = ~clk;

    serial_char_rx_ctrl #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .PARITY_EN  (PEN),
        .PARITY_ODD (PODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .in         (in_s),
        .out        (out),
        .on         (on),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Frame-level model: collect the bits of a frame, judge the complete frame, queue good characters.
    int mq[$];
    int bits[$];
    int mode = 0;        // 0 waiting for start, 1 collecting frame, 2 line held low after framing error
    int e_out = 0, e_cnt = 0;
    bit e_on = 0, e_fe = 0, e_pe = 0, e_ov = 0, e_busy = 0;
    bit chk_en = 0;

    always @(posedge clk) begin : model
        bit pop, push;
        int ch, ones;
        if (rst) begin
            mq.delete();
            bits.delete();
            mode  = 0;
            e_fe  = 0;
            e_pe  = 0;
            e_ov  = 0;
            e_out = 0;
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            push = 0;
            ch   = 0;
            e_fe = 0;
            e_pe = 0;
            e_ov = 0;
            if (bit_en) begin
                if (mode == 0) begin
                    if (!in_s) begin
                        mode = 1;
                        bits.delete();
                    end
                end else if (mode == 1) begin
                    bits.push_back(int'(in_s));
                    if (bits.size() == DATA_W + PEN + 1) begin
                        for (int i = 0; i < DATA_W; i++) ch = ch * 2 + bits[i];
                        ones = $countones(ch) + ((PEN != 0) ? bits[DATA_W] : 0);
                        if (bits[bits.size()-1] == 0) begin
                            e_fe = 1;
                            mode = 2;
                        end else if ((PEN != 0) && ((ones % 2) != PODD)) begin
                            e_pe = 1;
                            mode = 0;
                        end else begin
                            push = 1;
                            mode = 0;
                        end
                    end
                end else if (in_s) begin
                    mode = 0;
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(ch);
                else e_ov = 1;
            end
            if (mq.size() > 0) e_out = mq[0];
        end
        e_on   = (mq.size() > 0);
        e_cnt  = mq.size();
        e_busy = (mode != 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("on", on, e_on);
            check("fifo_count", fifo_count, e_cnt);
            check("busy", busy, e_busy);
            check("frame_err", frame_err, e_fe);
            check("parity_err", parity_err, e_pe);
            check("overflow", overflow, e_ov);
            if (e_on) check("out", out, e_out);
        end
    end

    int n_fe = 0, n_pe = 0, n_ov = 0, n_rx = 0;
    int rxq[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (frame_err)  n_fe++;
            if (parity_err) n_pe++;
            if (overflow)   n_ov++;
            if (on && out_ready) begin
                n_rx++;
                rxq.push_back(int'(out));
            end
        end
    end

    // rdy: -1 leaves out_ready alone, 0/1 forces it, 2 randomizes it
    task automatic set_ready(input int rdy);
        if (rdy == 0 || rdy == 1) out_ready = rdy[0];
        else if (rdy == 2) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic strobe(input logic b, input int gap, input int rdy);
        @(negedge clk);
        in_s   = b;
        bit_en = 1'b1;
        set_ready(rdy);
        for (int k = 1; k < gap; k++) begin
            @(negedge clk);
            bit_en = 1'b0;
            in_s   = 1'($urandom_range(0, 1));
            set_ready((rdy == 1) ? 0 : rdy);
        end
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bit_en = 1'b0;
            in_s   = 1'b1;
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] ch, input bit bad_par, input bit bad_stop,
                        input int gap, input int rdy, input int stop_rdy);
        logic pbit;
        pbit = 1'(($countones(ch) & 1) ^ PODD) ^ bad_par;
        strobe(1'b0, gap, rdy);
        for (int i = DATA_W - 1; i >= 0; i--) strobe(ch[i], gap, rdy);
        if (PEN != 0) strobe(pbit, gap, rdy);
        strobe(!bad_stop, gap, stop_rdy);
    endtask

    int b_fe, b_pe, b_ov, b_rx;

    task automatic mark();
        b_fe = n_fe;
        b_pe = n_pe;
        b_ov = n_ov;
        b_rx = n_rx;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_on", on, 0);
        check("rst_out", out, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_errs", {frame_err, parity_err, overflow}, 0);
        rst    = 1'b0;
        chk_en = 1;

        // 'A' with correct even parity: on for one cycle after the stop edge
        mark();
        out_ready = 1'b1;
        send(7'h41, 0, 0, 1, -1, -1);
        quiet(1);
        check("A_on", on, 1);
        check("A_out", out, 'h41);
        quiet(2);
        check("A_on_after_pop", on, 0);
        check("A_no_err", (n_fe - b_fe) + (n_pe - b_pe), 0);

        // 'C' with wrong parity bit
        mark();
        send(7'h43, 1, 0, 1, -1, -1);
        quiet(2);
        check("C_parity_pulses", n_pe - b_pe, 1);
        check("C_count", fifo_count, 0);
        check("C_no_rx", n_rx - b_rx, 0);

        // framing error, line held low, then recovery
        mark();
        send(7'h41, 0, 1, 1, -1, -1);
        for (int i = 0; i < 5; i++) strobe(1'b0, 1, -1);
        strobe(1'b1, 1, -1);
        send(7'h41, 0, 0, 1, -1, -1);
        quiet(2);
        check("brk_frame_pulses", n_fe - b_fe, 1);
        check("brk_parity_pulses", n_pe - b_pe, 0);
        check("brk_rx_count", n_rx - b_rx, 1);
        check("brk_rx_char", rxq[rxq.size()-1], 'h41);

        // fill with consumer stalled, overflow on the fifth character, then drain
        mark();
        out_ready = 1'b0;
        for (int c = 'h41; c <= 'h45; c++) send(7'(c), 0, 0, 1, -1, -1);
        quiet(2);
        check("ovf_count", fifo_count, 4);
        check("ovf_pulses", n_ov - b_ov, 1);
        out_ready = 1'b1;
        quiet(6);
        check("drain_rx_count", n_rx - b_rx, 4);
        for (int i = 0; i < 4; i++) check("drain_order", rxq[rxq.size()-4+i], 'h41 + i);

        // full FIFO with a pop on the stop-bit edge
        mark();
        out_ready = 1'b0;
        for (int c = 'h50; c <= 'h53; c++) send(7'(c), 0, 0, 1, -1, -1);
        send(7'h54, 0, 0, 1, -1, 1);
        quiet(1);
        out_ready = 1'b0;
        quiet(1);
        check("pop_full_count", fifo_count, 4);
        check("pop_full_ovf", n_ov - b_ov, 0);
        out_ready = 1'b1;
        quiet(6);
        check("pop_full_rx_count", n_rx - b_rx, 5);
        for (int i = 0; i < 5; i++) check("pop_full_order", rxq[rxq.size()-5+i], 'h50 + i);

        // slow strobes, reset mid-frame with a character waiting
        out_ready = 1'b0;
        send(7'h11, 0, 0, 3, -1, -1);
        quiet(1);
        strobe(1'b0, 3, -1);
        strobe(1'b1, 3, -1);
        strobe(1'b0, 3, -1);
        @(negedge clk);
        bit_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_on", on, 0);
        check("mid_rst_out", out, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_errs", {frame_err, parity_err, overflow}, 0);
        rst = 1'b0;
        mark();
        out_ready = 1'b1;
        send(7'h5A, 0, 0, 3, -1, -1);
        quiet(3);
        check("post_rst_rx_count", n_rx - b_rx, 1);
        check("post_rst_rx_char", rxq[rxq.size()-1], 'h5A);

        // randomized traffic checked by the model every cycle
        for (int f = 0; f < 250; f++) begin
            int gap, idle;
            bit bp, bs;
            gap = $urandom_range(1, 3);
            bp  = ($urandom_range(0, 9) == 0);
            bs  = ($urandom_range(0, 9) == 0);
            send(7'($urandom_range(0, 127)), bp, bs, gap, 2, 2);
            if (bs) for (int i = 0; i < int'($urandom_range(0, 3)); i++) strobe(1'b0, gap, 2);
            idle = $urandom_range(bs ? 1 : 0, 2);
            for (int i = 0; i < idle; i++) strobe(1'b1, gap, 2);
        end
        out_ready = 1'b1;
        quiet(8);
        check("final_count", fifo_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
